// File: rtl/smachine_pkg.sv
// Shared opcode constants, state encoding and decode helpers for the sequencer.
package smachine_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StHalted = 3'd4
  } state_e;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLoad  = 4'h1;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpJmp   = 4'h3;
  localparam logic [3:0] OpBrz   = 4'h4;
  localparam logic [3:0] OpHalt  = 4'hF;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OpLoad) || (op == OpStore);
  endfunction

endpackage

// File: rtl/smachine_seq.sv
// Fetch/execute sequencer: fetches an instruction, sequences the data-memory
// access for LOAD/STORE, updates the PC and counts retired instructions.
module smachine_seq
  import smachine_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              step,
  output logic              inst_req,
  output logic [ADDR_W-1:0] PC,
  input  logic              inst_valid,
  input  logic [DATA_W-1:0] inst,
  output logic              mem_req,
  output logic              read_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out_memory,
  input  logic [DATA_W-1:0] data_in_memory,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] acc_in,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              halted,
  output logic [CNT_W-1:0]  count
);

  state_e            state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] operand_q;
  logic              step_pend;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_inst;

  assign pc_inc          = PC + ADDR_W'(1);
  assign data_out_memory = acc_in;
  // Only the opcode and operand fields of the instruction word are decoded.
  assign unused_inst     = ^inst;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= StIdle;
      op_q       <= 4'h0;
      operand_q  <= '0;
      step_pend  <= 1'b0;
      inst_req   <= 1'b0;
      PC         <= '0;
      mem_req    <= 1'b0;
      read_write <= 1'b0;
      addr       <= '0;
      ex_valid   <= 1'b0;
      ld_data    <= '0;
      halted     <= 1'b0;
      count      <= '0;
    end else begin
      ex_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (enable || step || step_pend) begin
            state    <= StFetch;
            inst_req <= 1'b1;
            if (step) step_pend <= 1'b1;
          end
        end

        StFetch: begin
          if (inst_req && inst_valid) begin
            op_q      <= inst[DATA_W-1 -: 4];
            operand_q <= inst[ADDR_W-1:0];
            inst_req  <= 1'b0;
            state     <= StExec;
          end
        end

        StExec: begin
          if (is_mem_op(op_q)) begin
            state      <= StMem;
            mem_req    <= 1'b1;
            addr       <= operand_q;
            read_write <= (op_q == OpStore);
          end else begin
            ex_valid  <= 1'b1;
            count     <= count + CNT_W'(1);
            step_pend <= 1'b0;
            case (op_q)
              OpJmp:   PC <= operand_q;
              OpBrz:   PC <= (acc_in == '0) ? operand_q : pc_inc;
              OpHalt:  PC <= PC;
              default: PC <= pc_inc;
            endcase
            if (op_q == OpHalt) begin
              state  <= StHalted;
              halted <= 1'b1;
            end else begin
              // Dropping enable lets the current instruction finish, then parks.
              state    <= enable ? StFetch : StIdle;
              inst_req <= enable;
            end
          end
        end

        StMem: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            if (op_q == OpLoad) ld_data <= data_in_memory;
            PC        <= pc_inc;
            ex_valid  <= 1'b1;
            count     <= count + CNT_W'(1);
            step_pend <= 1'b0;
            state     <= enable ? StFetch : StIdle;
            inst_req  <= enable;
          end
        end

        StHalted: begin
          state <= StHalted;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_smachine_seq.sv
// Directed bench for smachine_seq: table of short programs plus hand-written
// sequences for memory waits, reset during MEM, halt stickiness and enable drop.
module tb_smachine_seq;
  import smachine_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, enable, step, inst_valid, mem_ack;
  logic [15:0] inst, data_in_memory, acc_in;
  logic        inst_req, mem_req, read_write, ex_valid, halted;
  logic [7:0]  PC, addr, count;
  logic [15:0] data_out_memory, ld_data;

  logic        inst_req4, mem_req4, read_write4, ex_valid4, halted4;
  logic [7:0]  pc4, addr4;
  logic [3:0]  count4;
  logic [15:0] dout4, ld_data4;

  smachine_seq dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .step(step),
    .inst_req(inst_req), .PC(PC), .inst_valid(inst_valid), .inst(inst),
    .mem_req(mem_req), .read_write(read_write), .addr(addr),
    .data_out_memory(data_out_memory), .data_in_memory(data_in_memory),
    .mem_ack(mem_ack), .acc_in(acc_in), .ex_valid(ex_valid), .ld_data(ld_data),
    .halted(halted), .count(count)
  );

  // Same stimulus, narrow counter, to observe modulo-16 wrap.
  smachine_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .step(step),
    .inst_req(inst_req4), .PC(pc4), .inst_valid(inst_valid), .inst(inst),
    .mem_req(mem_req4), .read_write(read_write4), .addr(addr4),
    .data_out_memory(dout4), .data_in_memory(data_in_memory),
    .mem_ack(mem_ack), .acc_in(acc_in), .ex_valid(ex_valid4), .ld_data(ld_data4),
    .halted(halted4), .count(count4)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int inst_wait = 0, mem_wait = 0;
  bit stale_ack = 0, force_iv = 0;
  int st_count = 0;
  logic [7:0]  st_addr = '0;
  logic [15:0] st_data = '0;

  // Memory responder: waits inst_wait / mem_wait request cycles, then completes.
  initial begin
    int icnt, mcnt;
    icnt = 0; mcnt = 0;
    inst_valid = 0; inst = '0; mem_ack = 0; data_in_memory = '0;
    forever begin
      @(negedge clk);
      if (inst_req) begin
        if (icnt == inst_wait) begin inst_valid = 1; inst = imem[PC]; end
        else inst_valid = 0;
        icnt++;
      end else begin
        icnt = 0; inst_valid = force_iv; inst = 16'h0000;
      end
      if (mem_req) begin
        if (mcnt == mem_wait) begin
          mem_ack = 1; data_in_memory = dmem[addr];
          if (read_write) begin st_count++; st_addr = addr; st_data = data_out_memory; end
        end else mem_ack = 0;
        mcnt++;
      end else begin
        mcnt = 0; mem_ack = stale_ack;
      end
    end
  end

  int pulses = 0, mreq_cycles = 0, mutex_viol = 0;
  logic [7:0]  last_addr = '0;
  logic        last_rw = 0;
  logic [15:0] last_ld = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (ex_valid) begin pulses++; last_ld = ld_data; end
      if (mem_req) begin mreq_cycles++; last_addr = addr; last_rw = read_write; end
      if (inst_req && mem_req) mutex_viol++;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [7:0] a);
    return {op, 4'h0, a};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; enable = 0; step = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin imem[i] = mk(OpNop, 8'h00); dmem[i] = '0; end
  endtask

  // which: 0 = ex_valid, 1 = mem_req, 2 = halted
  task automatic wait_for(input int which, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && ex_valid) || (which == 1 && mem_req) || (which == 2 && halted)) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic step_once(output bit ok);
    @(negedge clk); step = 1;
    @(negedge clk); step = 0;
    wait_for(0, 60, ok);
  endtask

  task automatic run_until_halt(output bit ok);
    @(negedge clk); enable = 1;
    wait_for(2, 400, ok);
    enable = 0;
  endtask

  typedef struct {
    bit          run;
    int          nsteps;
    int          iwait;
    logic [15:0] acc;
    logic [7:0]  a0; logic [15:0] w0;
    logic [7:0]  a1; logic [15:0] w1;
    logic [7:0]  a2; logic [15:0] w2;
    logic [7:0]  exp_pc;
    int          exp_cnt;
    bit          exp_halt;
    int          exp_st;
    logic [7:0]  st_a;
  } vec_t;

  localparam int NV = 9;
  vec_t  vecs  [NV];
  string vname [NV];

  initial begin
    bit ok, all_ok;
    int p0, s0, m0;
    reset_n = 0; enable = 0; step = 0; acc_in = '0;
    clear_mem();

    vname[0] = "run_nop_halt";
    vecs[0] = '{1, 0, 0, 16'h0, 8'h00, mk(OpNop, 0), 8'h01, mk(OpNop, 0), 8'h02, mk(OpHalt, 0),
                8'h02, 3, 1, 0, 8'h00};
    vname[1] = "step_one";
    vecs[1] = '{0, 1, 0, 16'h0, 8'h00, mk(OpNop, 0), 8'h01, mk(OpNop, 0), 8'h02, mk(OpNop, 0),
                8'h01, 1, 0, 0, 8'h00};
    vname[2] = "brz_taken";
    vecs[2] = '{0, 1, 0, 16'h0, 8'h00, mk(OpBrz, 8'h10), 8'h10, mk(OpNop, 0), 8'h01,
                mk(OpNop, 0), 8'h10, 1, 0, 0, 8'h00};
    vname[3] = "brz_not_taken";
    vecs[3] = '{0, 1, 0, 16'h1, 8'h00, mk(OpBrz, 8'h10), 8'h10, mk(OpNop, 0), 8'h01,
                mk(OpNop, 0), 8'h01, 1, 0, 0, 8'h00};
    vname[4] = "jmp_ff_wrap";
    vecs[4] = '{0, 2, 0, 16'h0, 8'h00, mk(OpJmp, 8'hFF), 8'hFF, mk(OpNop, 0), 8'h01,
                mk(OpNop, 0), 8'h00, 2, 0, 0, 8'h00};
    vname[5] = "jmp_fetch_wait";
    vecs[5] = '{0, 3, 2, 16'h0, 8'h00, mk(OpNop, 0), 8'h01, mk(OpJmp, 8'h40), 8'h40,
                mk(OpNop, 0), 8'h41, 3, 0, 0, 8'h00};
    vname[6] = "run_store_halt";
    vecs[6] = '{1, 0, 0, 16'h1234, 8'h00, mk(OpStore, 8'h30), 8'h01, mk(OpHalt, 0), 8'h02,
                mk(OpNop, 0), 8'h01, 2, 1, 1, 8'h30};
    vname[7] = "nop17_wrap";
    vecs[7] = '{0, 17, 0, 16'h0, 8'h00, mk(OpNop, 0), 8'h01, mk(OpNop, 0), 8'h02, mk(OpNop, 0),
                8'h11, 17, 0, 0, 8'h00};
    vname[8] = "run_brz_halt";
    vecs[8] = '{1, 0, 1, 16'h0, 8'h00, mk(OpNop, 0), 8'h01, mk(OpBrz, 8'h03), 8'h03,
                mk(OpHalt, 0), 8'h03, 3, 1, 0, 8'h00};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_pc", PC, 0);
    check("rst_count", count, 0);
    check("rst_halted", halted, 0);
    check("rst_inst_req", inst_req, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ld_data", ld_data, 0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      clear_mem();
      imem[vecs[i].a0] = vecs[i].w0;
      imem[vecs[i].a1] = vecs[i].w1;
      imem[vecs[i].a2] = vecs[i].w2;
      inst_wait = vecs[i].iwait; mem_wait = 0; acc_in = vecs[i].acc;
      repeat (2) @(negedge clk);
      p0 = pulses; s0 = st_count;
      all_ok = 1;
      if (vecs[i].run) run_until_halt(all_ok);
      else for (int k = 0; k < vecs[i].nsteps; k++) begin step_once(ok); all_ok &= ok; end
      repeat (3) @(negedge clk);
      check({vname[i], "_done"}, all_ok, 1);
      check({vname[i], "_pc"}, PC, vecs[i].exp_pc);
      check({vname[i], "_count"}, count, vecs[i].exp_cnt & 8'hFF);
      check({vname[i], "_count4"}, count4, vecs[i].exp_cnt % 16);
      check({vname[i], "_halted"}, halted, vecs[i].exp_halt);
      check({vname[i], "_pulses"}, pulses - p0, vecs[i].exp_cnt);
      check({vname[i], "_stores"}, st_count - s0, vecs[i].exp_st);
      if (vecs[i].exp_st != 0) begin
        check({vname[i], "_st_addr"}, st_addr, vecs[i].st_a);
        check({vname[i], "_st_data"}, st_data, vecs[i].acc);
      end
    end

    // LOAD with a three-cycle memory wait
    do_reset(); clear_mem();
    imem[0] = mk(OpLoad, 8'h20); dmem[8'h20] = 16'hBEEF;
    inst_wait = 0; mem_wait = 3;
    repeat (2) @(negedge clk);
    m0 = mreq_cycles; p0 = pulses;
    step_once(ok);
    repeat (3) @(negedge clk);
    check("ld_done", ok, 1);
    check("ld_mreq_cycles", mreq_cycles - m0, 4);
    check("ld_rw", last_rw, 0);
    check("ld_addr", last_addr, 8'h20);
    check("ld_data", last_ld, 16'hBEEF);
    check("ld_pc", PC, 1);
    check("ld_count", count, 1);
    check("ld_pulses", pulses - p0, 1);

    // Reset while waiting in MEM; stale ack / inst_valid afterwards ignored
    do_reset(); clear_mem();
    imem[1] = mk(OpLoad, 8'h20);
    mem_wait = 1000;
    step_once(ok);
    @(negedge clk); step = 1;
    @(negedge clk); step = 0;
    wait_for(1, 30, ok);
    repeat (2) @(negedge clk);
    check("rm_reached_mem", ok, 1);
    check("rm_pre_pc", PC, 1);
    check("rm_pre_count", count, 1);
    reset_n = 0;
    @(negedge clk);
    check("rm_mem_req", mem_req, 0);
    check("rm_pc", PC, 0);
    check("rm_count", count, 0);
    reset_n = 1; stale_ack = 1; force_iv = 1;
    p0 = pulses;
    repeat (4) @(negedge clk);
    stale_ack = 0; force_iv = 0; mem_wait = 0;
    repeat (2) @(negedge clk);
    check("rm_stale_pulses", pulses - p0, 0);
    check("rm_stale_count", count, 0);
    check("rm_stale_pc", PC, 0);
    check("rm_stale_inst_req", inst_req, 0);

    // HALTED ignores enable and step
    do_reset(); clear_mem();
    imem[1] = mk(OpHalt, 8'h00);
    run_until_halt(ok);
    check("hl_done", ok, 1);
    @(negedge clk); enable = 1; step = 1;
    @(negedge clk); step = 0;
    repeat (10) @(negedge clk);
    check("hl_halted", halted, 1);
    check("hl_count", count, 2);
    check("hl_pc", PC, 1);
    check("hl_inst_req", inst_req, 0);
    enable = 0;

    // enable dropped during MEM: LOAD completes, then parks in IDLE
    do_reset(); clear_mem();
    imem[0] = mk(OpLoad, 8'h20); dmem[8'h20] = 16'h5A5A;
    mem_wait = 3;
    @(negedge clk); enable = 1;
    wait_for(1, 30, ok);
    enable = 0;
    check("ed_reached_mem", ok, 1);
    wait_for(0, 30, ok);
    repeat (4) @(negedge clk);
    check("ed_done", ok, 1);
    check("ed_count", count, 1);
    check("ed_pc", PC, 1);
    check("ed_ld_data", ld_data, 16'h5A5A);
    check("ed_inst_req", inst_req, 0);
    check("ed_mem_req", mem_req, 0);
    mem_wait = 0;

    check("req_mutex_violations", mutex_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
